// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches and buffers in-order responses for decode (bypass: FETCH_QUEUE_BYPASS_EN).
// Latency: response to inst_valid is 1 cycle, or 0 cycles with FETCH_QUEUE_BYPASS_EN when the queue is empty.
// Backpressure: requests are held while count + outstanding >= DEPTH; responses are never stalled, and redirect discards in-flight ones.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_data,
  output logic [XLEN-1:0]            inst_pc,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  // Stale responses can pile up across repeated redirects, so this is wider than the queue.
  localparam int SW = 16;

  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d, outst_q, outst_d;
  logic [SW-1:0]   stale_q, stale_d;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     data_d [DEPTH];
  logic [XLEN-1:0] epc_q  [DEPTH];
  logic [XLEN-1:0] epc_d  [DEPTH];
  logic [CW:0]     inflight;
  logic            req_fire, rsp_live, push, pop, bypass;

  always_comb begin
    inflight       = {1'b0, count_q} + {1'b0, outst_q};
    imem_req_valid = !reset && !redirect_valid && (inflight < (CW+1)'(DEPTH));
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // Responses are in order, so only the first non-stale one belongs to rsp_pc_q.
    rsp_live       = imem_rsp_valid && (stale_q == '0) && !redirect_valid && !reset;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass         = rsp_live && (count_q == '0) && inst_ready;
    inst_valid     = (count_q != '0) || rsp_live;
    inst_data      = (count_q != '0) ? data_q[head_q] : imem_rsp_data;
    inst_pc        = (count_q != '0) ? epc_q[head_q] : rsp_pc_q;
`else
    bypass         = 1'b0;
    inst_valid     = (count_q != '0);
    inst_data      = data_q[head_q];
    inst_pc        = epc_q[head_q];
`endif
    push           = rsp_live && !bypass;
    pop            = inst_ready && (count_q != '0);
    count          = count_q;
  end

  always_comb begin
    pc_d     = req_fire ? pc_q + XLEN'(4) : pc_q;
    rsp_pc_d = rsp_live ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
    head_d   = pop  ? head_q + PW'(1) : head_q;
    tail_d   = push ? tail_q + PW'(1) : tail_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    outst_d  = outst_q + CW'(req_fire) - CW'(rsp_live);
    stale_d  = stale_q - SW'(imem_rsp_valid && (stale_q != '0));
    data_d   = data_q;
    epc_d    = epc_q;
    if (push) begin
      data_d[tail_q] = imem_rsp_data;
      epc_d[tail_q]  = rsp_pc_q;
    end
    // Redirect wins: everything in flight becomes stale, including a response landing now.
    if (redirect_valid) begin
      pc_d     = redirect_pc & ~XLEN'(3);
      rsp_pc_d = redirect_pc & ~XLEN'(3);
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      outst_d  = '0;
      stale_d  = stale_q + SW'(outst_q) - SW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      stale_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      stale_q  <= stale_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    epc_q  <= epc_d;
  end

endmodule
